// File: rtl/ring_rotation_sequencer.sv
// ring_rotation_sequencer
// Sequencer for the dual recirculating ring display datapath (ring A 6 bits,
// ring B 8 bits). Runs the synchronous preload of both rings, generates the
// prescaled rotation strobes with direction, tracks both ring positions and
// alternates the displayed ring on completed ring-B revolutions.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no rotation; waits for load_req (preload) or run (rotate)
// LOAD_A | ring A parallel-load strobe is out, pos_a cleared
// LOAD_B | ring B parallel-load strobe is out, pos_b cleared
// RUN    | prescaler counting; each tick rotates both rings one place
//
// Every output comes straight from a flop, so a strobe appears in the cycle
// after the edge that decided it. ena low freezes all state and silences
// the strobes.

module ring_rotation_sequencer #(
  parameter int PRESCALE_W = 16,
  parameter int RING_A_LEN = 6,
  parameter int RING_B_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [PRESCALE_W-1:0] cfg_period,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  alt_en,
  input  logic                  load_req,
  input  logic [7:0]            pattern_in,
  output logic                  load_a,
  output logic                  load_b,
  output logic [7:0]            load_data,
  output logic                  shift_a,
  output logic                  shift_b,
  output logic                  shift_dir,
  output logic [2:0]            pos_a,
  output logic [2:0]            pos_b,
  output logic                  disp_sel,
  output logic                  rev_done,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_A = 2'd1;
  localparam logic [1:0] S_LOAD_B = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  localparam logic [PRESCALE_W-1:0] CNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  localparam logic [2:0] A_LAST = 3'(RING_A_LEN - 1);
  localparam logic [2:0] B_LAST = 3'(RING_B_LEN - 1);

  logic [1:0]            r_state;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [7:0]            r_latch;
  logic [7:0]            r_load_data;
  logic                  r_load_a;
  logic                  r_load_b;
  logic                  r_busy;
  logic                  r_shift_a;
  logic                  r_shift_b;
  logic                  r_shift_dir;
  logic                  r_rev_done;
  logic [2:0]            r_pos_a;
  logic [2:0]            r_pos_b;
  logic                  r_disp_sel;

  logic [1:0]            w_next_state;
  logic [PRESCALE_W-1:0] w_last;
  logic                  w_start_load;
  logic                  w_run_hold;
  logic                  w_tick;
  logic [2:0]            w_pos_a_nxt;
  logic [2:0]            w_pos_b_nxt;
  logic                  w_wrap_b;

  // Terminal count of the prescaler; a period of 0 behaves as a period of 1.
  always_comb begin
    w_last = '0;
    if (cfg_period != '0) begin
      w_last = cfg_period - CNT_ONE;
    end
  end

  // Decode of the events that drive every register below. A load request
  // outranks both a run drop and a coinciding tick, so the tick is lost.
  always_comb begin
    w_start_load = load_req && ((r_state == S_IDLE) || (r_state == S_RUN));
    w_run_hold   = (r_state == S_RUN) && !load_req && run;
    // >= rather than == so a period shortened below the running count
    // fires on the very next edge instead of wrapping the counter.
    w_tick       = w_run_hold && (r_cnt >= w_last);
  end

  // Next-state selection for the load / rotate sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_req) begin
          w_next_state = S_LOAD_A;
        end else if (run) begin
          w_next_state = S_RUN;
        end
      end
      S_LOAD_A: w_next_state = S_LOAD_B;
      S_LOAD_B: w_next_state = run ? S_RUN : S_IDLE;
      S_RUN: begin
        if (load_req) begin
          w_next_state = S_LOAD_A;
        end else if (!run) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Ring position successors for the current direction, plus ring-B wrap.
  always_comb begin
    if (dir) begin
      w_pos_a_nxt = (r_pos_a == A_LAST) ? 3'd0 : r_pos_a + 3'd1;
      w_pos_b_nxt = (r_pos_b == B_LAST) ? 3'd0 : r_pos_b + 3'd1;
      w_wrap_b    = (r_pos_b == B_LAST);
    end else begin
      w_pos_a_nxt = (r_pos_a == 3'd0) ? A_LAST : r_pos_a - 3'd1;
      w_pos_b_nxt = (r_pos_b == 3'd0) ? B_LAST : r_pos_b - 3'd1;
      w_wrap_b    = (r_pos_b == 3'd0);
    end
  end

  // FSM state register and the busy flag that mirrors the load states.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else if (ena) begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_LOAD_A) || (w_next_state == S_LOAD_B);
    end
  end

  // Step-period prescaler: counts only while rotation continues, cleared on
  // every RUN entry, run drop, load request and tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (ena) begin
      if (w_run_hold && !w_tick) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Pattern latch and the two-cycle preload strobe sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_latch     <= '0;
      r_load_data <= '0;
      r_load_a    <= 1'b0;
      r_load_b    <= 1'b0;
    end else if (!ena) begin
      r_load_a <= 1'b0;
      r_load_b <= 1'b0;
    end else begin
      r_load_a <= w_start_load;
      r_load_b <= (r_state == S_LOAD_A);
      if (w_start_load) begin
        r_latch     <= pattern_in;
        r_load_data <= pattern_in;
      end else if (r_state == S_LOAD_A) begin
        r_load_data <= r_latch;
      end else if (r_state == S_LOAD_B) begin
        r_load_data <= '0;
      end
    end
  end

  // Rotation strobes; direction and revolution flag ride on the tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift_a   <= 1'b0;
      r_shift_b   <= 1'b0;
      r_shift_dir <= 1'b0;
      r_rev_done  <= 1'b0;
    end else begin
      r_shift_a   <= ena && w_tick;
      r_shift_b   <= ena && w_tick;
      r_shift_dir <= ena && w_tick && dir;
      r_rev_done  <= ena && w_tick && w_wrap_b;
    end
  end

  // Ring positions (cleared by the matching load state) and display select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pos_a    <= 3'd0;
      r_pos_b    <= 3'd0;
      r_disp_sel <= 1'b0;
    end else if (ena) begin
      if (w_start_load) begin
        r_pos_a <= 3'd0;
      end else if (w_tick) begin
        r_pos_a <= w_pos_a_nxt;
      end
      if (r_state == S_LOAD_A) begin
        r_pos_b <= 3'd0;
      end else if (w_tick) begin
        r_pos_b <= w_pos_b_nxt;
      end
      if (w_tick && w_wrap_b && alt_en) begin
        r_disp_sel <= ~r_disp_sel;
      end
    end
  end

  assign load_a    = r_load_a;
  assign load_b    = r_load_b;
  assign load_data = r_load_data;
  assign shift_a   = r_shift_a;
  assign shift_b   = r_shift_b;
  assign shift_dir = r_shift_dir;
  assign pos_a     = r_pos_a;
  assign pos_b     = r_pos_b;
  assign disp_sel  = r_disp_sel;
  assign rev_done  = r_rev_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ring_rotation_sequencer.sv
// Testbench for ring_rotation_sequencer: directed scenarios plus a random
// run, all compared cycle by cycle against a behavioural model of the rings.
`timescale 1ns/1ps

module tb_ring_rotation_sequencer;

  localparam int PW = 16;
  localparam int RA = 6;
  localparam int RB = 8;

  localparam int M_IDLE = 0;
  localparam int M_LA   = 1;
  localparam int M_LB   = 2;
  localparam int M_RUN  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic [PW-1:0] cfg_period = '0;
  logic          run = 1'b0;
  logic          dir = 1'b1;
  logic          alt_en = 1'b0;
  logic          load_req = 1'b0;
  logic [7:0]    pattern_in = 8'h00;
  logic          load_a, load_b, shift_a, shift_b, shift_dir;
  logic [7:0]    load_data;
  logic [2:0]    pos_a, pos_b;
  logic          disp_sel, rev_done, busy;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;

  // behavioural model state
  int       m_mode = M_IDLE;
  int       m_since = 0;
  int       m_pos_a = 0;
  int       m_pos_b = 0;
  logic     m_disp = 1'b0;
  logic [7:0] m_latch = 8'h00;
  logic [7:0] e_data = 8'h00;
  logic     e_load_a = 0, e_load_b = 0, e_shift = 0, e_shift_dir = 0, e_rev = 0, e_busy = 0;

  logic [21:0] obs;
  logic [21:0] expv;

  ring_rotation_sequencer #(.PRESCALE_W(PW), .RING_A_LEN(RA), .RING_B_LEN(RB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_period(cfg_period), .run(run),
    .dir(dir), .alt_en(alt_en), .load_req(load_req), .pattern_in(pattern_in),
    .load_a(load_a), .load_b(load_b), .load_data(load_data),
    .shift_a(shift_a), .shift_b(shift_b), .shift_dir(shift_dir),
    .pos_a(pos_a), .pos_b(pos_b), .disp_sel(disp_sel), .rev_done(rev_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  assign obs = {load_a, load_b, load_data, shift_a, shift_b, shift_dir,
                pos_a, pos_b, disp_sel, rev_done, busy};

  always_comb begin
    expv = {e_load_a, e_load_b, e_data, e_shift, e_shift, e_shift_dir,
            m_pos_a[2:0], m_pos_b[2:0], m_disp, e_rev, e_busy};
  end

  // One rotation step of both rings in the given direction.
  task automatic model_step();
    e_shift     = 1'b1;
    e_shift_dir = dir;
    m_pos_a = (m_pos_a + (dir ? 1 : RA - 1)) % RA;
    m_pos_b = (m_pos_b + (dir ? 1 : RB - 1)) % RB;
    e_rev = dir ? (m_pos_b == 0) : (m_pos_b == RB - 1);
    if (e_rev && alt_en) m_disp = ~m_disp;
  endtask

  // Predicted outputs after one clock edge with the inputs currently applied.
  task automatic model_edge();
    int p;
    e_load_a = 0; e_load_b = 0; e_shift = 0; e_shift_dir = 0; e_rev = 0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_since = 0; m_pos_a = 0; m_pos_b = 0;
      m_disp = 0; m_latch = 0; e_data = 0; e_busy = 0;
    end else if (ena) begin
      p = (cfg_period == 0) ? 1 : int'(cfg_period);
      if ((m_mode == M_IDLE || m_mode == M_RUN) && load_req) begin
        m_mode = M_LA; m_latch = pattern_in; e_data = pattern_in;
        e_load_a = 1; m_pos_a = 0;
      end else if (m_mode == M_IDLE) begin
        if (run) begin m_mode = M_RUN; m_since = 0; end
      end else if (m_mode == M_LA) begin
        m_mode = M_LB; e_load_b = 1; e_data = m_latch; m_pos_b = 0;
      end else if (m_mode == M_LB) begin
        m_mode = run ? M_RUN : M_IDLE; m_since = 0; e_data = 0;
      end else if (!run) begin
        m_mode = M_IDLE; m_since = 0;
      end else begin
        m_since++;
        if (m_since >= p) begin
          m_since = 0;
          model_step();
        end
      end
      e_busy = (m_mode == M_LA) || (m_mode == M_LB);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    cyc_n++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; load_req = 0; run = 0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (obs !== 22'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc_n, obs, 22'h0);
      end
    end
    rst_n = 1;
  endtask

  task automatic test_load();
    load_req = 1; pattern_in = 8'hA5; run = 0;
    cyc();
    load_req = 0; pattern_in = 8'h3C;
    checks++;
    if (load_a !== 1'b1 || load_b !== 1'b0 || load_data !== 8'hA5 || busy !== 1'b1 || pos_a !== 3'd0) begin
      errors++;
      $display("FAIL load_a_cycle got la=%b lb=%b data=%h busy=%b pa=%0d exp la=1 lb=0 data=a5 busy=1 pa=0",
               load_a, load_b, load_data, busy, pos_a);
    end
    cyc();
    checks++;
    if (load_a !== 1'b0 || load_b !== 1'b1 || load_data !== 8'hA5 || busy !== 1'b1 || pos_b !== 3'd0) begin
      errors++;
      $display("FAIL load_b_cycle got la=%b lb=%b data=%h busy=%b pb=%0d exp la=0 lb=1 data=a5 busy=1 pb=0",
               load_a, load_b, load_data, busy, pos_b);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (load_a !== 1'b0 || load_b !== 1'b0 || busy !== 1'b0 || shift_a !== 1'b0) begin
        errors++;
        $display("FAIL load_idle cyc=%0d got la=%b lb=%b busy=%b sa=%b exp all 0",
                 cyc_n, load_a, load_b, busy, shift_a);
      end
    end
  endtask

  task automatic test_forward();
    int ticks = 0;
    cfg_period = 16'd3; dir = 1; run = 1; alt_en = 0;
    cyc();
    for (int k = 1; k <= 30; k++) begin
      cyc();
      checks++;
      if (shift_a !== ((k % 3) == 0) || shift_b !== ((k % 3) == 0)) begin
        errors++;
        $display("FAIL fwd_tick_timing k=%0d got sa=%b sb=%b exp %b", k, shift_a, shift_b, (k % 3) == 0);
      end
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL fwd_model k=%0d got=%h exp=%h", k, obs, expv);
      end
      if (shift_a === 1'b1) begin
        ticks++;
        if (ticks == 6) begin
          checks++;
          if (pos_a !== 3'd0 || shift_dir !== 1'b1) begin
            errors++;
            $display("FAIL fwd_pos_a_wrap got pa=%0d dir=%b exp pa=0 dir=1", pos_a, shift_dir);
          end
        end
        if (ticks == 8) begin
          checks++;
          if (pos_b !== 3'd0 || rev_done !== 1'b1) begin
            errors++;
            $display("FAIL fwd_pos_b_wrap got pb=%0d rev=%b exp pb=0 rev=1", pos_b, rev_done);
          end
        end
      end
    end
    run = 0;
    cyc();
    checks++;
    if (obs !== expv || shift_a !== 1'b0) begin
      errors++;
      $display("FAIL fwd_stop got=%h exp=%h", obs, expv);
    end
  endtask

  task automatic test_reverse_alt();
    int want_b;
    load_req = 1; pattern_in = 8'($urandom); run = 1; cfg_period = 16'd0; dir = 0; alt_en = 1;
    cyc();
    load_req = 0;
    cyc();
    cyc();
    for (int k = 1; k <= 9; k++) begin
      cyc();
      want_b = (8 - (k % 8)) % 8;
      checks++;
      if (shift_a !== 1'b1 || shift_dir !== 1'b0 || pos_b !== 3'(want_b)) begin
        errors++;
        $display("FAIL rev_step k=%0d got sa=%b dir=%b pb=%0d exp sa=1 dir=0 pb=%0d",
                 k, shift_a, shift_dir, pos_b, want_b);
      end
      checks++;
      if (disp_sel !== ((k >= 1 && k <= 8) ? 1'b1 : 1'b0) || rev_done !== (k == 1 || k == 9)) begin
        errors++;
        $display("FAIL rev_alt k=%0d got disp=%b rev=%b", k, disp_sel, rev_done);
      end
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL rev_model k=%0d got=%h exp=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_collision();
    int saved_b;
    logic [7:0] pat;
    bit found = 0;
    cfg_period = 16'd4; dir = 1; alt_en = 0; run = 1;
    for (int i = 0; i < 20; i++) begin
      if (m_mode == M_RUN && m_since == 3) begin found = 1; break; end
      cyc();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL collision_timeout got no tick window exp window within 20 cycles");
    end
    saved_b = m_pos_b;
    pat = 8'($urandom);
    load_req = 1; pattern_in = pat;
    cyc();
    load_req = 0;
    checks++;
    if (shift_a !== 1'b0 || shift_b !== 1'b0 || load_a !== 1'b1 || pos_b !== 3'(saved_b) || load_data !== pat) begin
      errors++;
      $display("FAIL collision_load got sa=%b sb=%b la=%b pb=%0d data=%h exp sa=0 sb=0 la=1 pb=%0d data=%h",
               shift_a, shift_b, load_a, pos_b, load_data, saved_b, pat);
    end
    cyc();
    checks++;
    if (load_b !== 1'b1 || shift_a !== 1'b0) begin
      errors++;
      $display("FAIL collision_load_b got lb=%b sa=%b exp lb=1 sa=0", load_b, shift_a);
    end
    cyc();
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++;
      if (shift_a !== (k == 4) || obs !== expv) begin
        errors++;
        $display("FAIL collision_resume k=%0d got sa=%b obs=%h exp sa=%b obs=%h",
                 k, shift_a, obs, k == 4, expv);
      end
    end
  endtask

  task automatic test_cfg_change();
    bit found = 0;
    cfg_period = 16'd10;
    for (int i = 0; i < 30; i++) begin
      if (m_mode == M_RUN && m_since == 6) begin found = 1; break; end
      cyc();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL cfg_timeout got no count 6 exp within 30 cycles");
    end
    cfg_period = 16'd3; dir = 0;
    cyc();
    checks++;
    if (shift_a !== 1'b1 || shift_dir !== 1'b0 || obs !== expv) begin
      errors++;
      $display("FAIL cfg_shrink got sa=%b dir=%b obs=%h exp sa=1 dir=0 obs=%h", shift_a, shift_dir, obs, expv);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++;
      if (shift_a !== (k == 3 || k == 6) || obs !== expv) begin
        errors++;
        $display("FAIL cfg_after k=%0d got=%h exp=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_freeze_abort();
    logic [2:0] sa, sb;
    cfg_period = 16'd5; dir = 1; run = 1;
    cyc(); cyc();
    sa = m_pos_a[2:0]; sb = m_pos_b[2:0];
    ena = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (shift_a !== 1'b0 || shift_b !== 1'b0 || rev_done !== 1'b0 || pos_a !== sa || pos_b !== sb) begin
        errors++;
        $display("FAIL freeze k=%0d got sa=%b pa=%0d pb=%0d exp sa=0 pa=%0d pb=%0d",
                 k, shift_a, pos_a, pos_b, sa, sb);
      end
    end
    ena = 1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL freeze_resume k=%0d got=%h exp=%h", k, obs, expv);
      end
    end
    load_req = 1; pattern_in = 8'h5A;
    cyc();
    load_req = 0;
    cyc();
    checks++;
    if (load_b !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got lb=%b exp lb=1", load_b);
    end
    rst_n = 0;
    cyc();
    checks++;
    if (obs !== 22'h0) begin
      errors++;
      $display("FAIL abort_reset got=%h exp=%h", obs, 22'h0);
    end
    rst_n = 1; run = 0;
    cyc();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      ena      = ($urandom_range(0, 9) != 0);
      run      = ($urandom_range(0, 19) > 2);
      load_req = ($urandom_range(0, 29) == 0);
      pattern_in = 8'($urandom);
      if ($urandom_range(0, 9) == 0) cfg_period = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 19) == 0) alt_en = ~alt_en;
      cyc();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random k=%0d got=%h exp=%h", k, obs, expv);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_load();
    test_forward();
    test_reverse_alt();
    test_collision();
    test_cfg_change();
    test_freeze_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
